// File: rtl/truth_lut_pkg.sv
// Shared types and helpers for the settled truth-table gate.
// Optional glitch counter (TRUTH_LUT_GLITCH_CNT_EN) uses GLITCH_W.
package truth_lut_pkg;

    localparam int GLITCH_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } cfg_state_e;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_lut_settle.sv
// Input stability tracker: captures in_vec and flags when it has held for SETTLE edges.
// With TRUTH_LUT_GLITCH_CNT_EN defined it also counts settles aborted by a new change.
module truth_lut_settle
    import truth_lut_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IN-1:0]     in_vec,
    output logic [N_IN-1:0]     in_q,
    output logic                stable_pulse,
    output logic                settled
`ifdef TRUTH_LUT_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int            CW      = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE);
    localparam logic [CW-1:0] CNT_PRE = CW'(SETTLE - 1);

    logic [CW-1:0] stab_cnt;
    logic          changed;

    assign changed = (in_vec != in_q);

    // High on every edge at which out must sample the table: count completing or saturated.
    assign stable_pulse = !changed && (stab_cnt >= CNT_PRE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q     <= '0;
            stab_cnt <= '0;
            settled  <= 1'b0;
        end else if (changed) begin
            in_q     <= in_vec;
            stab_cnt <= '0;
            settled  <= 1'b0;
        end else if (stab_cnt < CNT_MAX) begin
            stab_cnt <= stab_cnt + CW'(1);
            if (stab_cnt == CNT_PRE) begin
                settled <= 1'b1;
            end
        end
    end

`ifdef TRUTH_LUT_GLITCH_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (changed && (stab_cnt != '0) && (stab_cnt < CNT_MAX)
                     && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_W'(1);
        end
    end
`endif

endmodule

// File: rtl/truth_lut_settled.sv
// N-input truth-table gate with settle-filtered registered output and serial table reload.
// Define TRUTH_LUT_GLITCH_CNT_EN to expose the aborted-settle counter glitch_cnt.
module truth_lut_settled
    import truth_lut_pkg::*;
#(
    parameter int                         N_IN     = 3,
    parameter int                         SETTLE   = 4,
    parameter logic [tt_width(N_IN)-1:0]  TT_RESET = 8'hD7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IN-1:0]     in_vec,
    output logic                out,
    output logic                settled,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    output logic                cfg_ready,
    output logic                cfg_busy
`ifdef TRUTH_LUT_GLITCH_CNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    localparam int              TW       = tt_width(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TW - 1);

    logic [TW-1:0]   active;
    logic [TW-1:0]   shadow;
    logic [N_IN-1:0] in_q;
    logic [N_IN-1:0] idx;
    logic            stable_pulse;
    logic            xfer;
    cfg_state_e      state;

    assign xfer = cfg_valid && cfg_ready;

    truth_lut_settle #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_settle (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vec       (in_vec),
        .in_q         (in_q),
        .stable_pulse (stable_pulse),
        .settled      (settled)
`ifdef TRUTH_LUT_GLITCH_CNT_EN
        ,
        .glitch_cnt   (glitch_cnt)
`endif
    );

    // Bits collect in shadow; active only changes in the single COMMIT cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            shadow    <= '0;
            active    <= TT_RESET;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (xfer) begin
                        shadow[idx] <= cfg_bit;
                        cfg_busy    <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                        end else begin
                            state <= LOAD;
                            idx   <= idx + N_IN'(1);
                        end
                    end
                end
                COMMIT: begin
                    active    <= shadow;
                    idx       <= '0;
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    cfg_busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    cfg_ready <= 1'b1;
                    cfg_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= 1'b0;
        end else if (stable_pulse) begin
            out <= active[in_q];
        end
    end

endmodule
